ring_scan_ctrl: RTL

RING_SCAN_CTRL -- requirements
Module: ring_scan_ctrl

---
 rtl/ring_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ring_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a one-word pending write buffer.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits 0..2.
module ring_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic        clk_500hz,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_BLK  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_M1 = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  state_t      r_state;
  logic [1:0]  r_k;
  logic [7:0]  r_cnt;
  logic [15:0] r_active;
  logic [15:0] r_pend_data;
  logic        r_pend;
  logic        r_rdy_en;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_fd;

  state_t      w_state_nxt;
  logic [1:0]  w_k_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_frame_start;
  logic        w_commit;
  logic        w_xfer;
  logic [15:0] w_active_nxt;
  logic [3:0]  w_nib;
  logic        w_lz;
  logic [6:0]  w_dec;
  logic [3:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;

  // Handshake: a word transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready is high whenever the single pending slot is empty (and not in reset).
  assign wr_ready    = r_rdy_en & ~r_pend;
  assign an          = r_an;
  assign seg         = r_seg;
  assign frame_done  = r_fd;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_cnt_nxt     = r_cnt;
    w_frame_start = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_k_nxt     = 2'd0;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_ON;
          w_k_nxt       = 2'd0;
          w_cnt_nxt     = 8'd0;
          w_frame_start = 1'b1;
        end
        S_ON: begin
          if (r_cnt == DWELL_M1) begin
            w_cnt_nxt = 8'd0;
            if (BLANK != 0) begin
              w_state_nxt = S_BLK;
            end else begin
              w_k_nxt       = r_k + 2'd1;
              w_frame_start = (r_k == 2'd3);
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_BLK: begin
          if (r_cnt == BLANK_M1) begin
            w_state_nxt   = S_ON;
            w_k_nxt       = r_k + 2'd1;
            w_cnt_nxt     = 8'd0;
            w_frame_start = (r_k == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 2'd0;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Commit looks only at the pending flag held before this edge's transfer.
  assign w_commit     = w_frame_start & r_pend;
  assign w_xfer       = wr_valid & wr_ready;
  assign w_active_nxt = w_commit ? r_pend_data : r_active;

  always_comb begin
    w_nib = 4'h0;
    w_lz  = 1'b0;
    case (w_k_nxt)
      2'd0: begin w_nib = w_active_nxt[15:12]; w_lz = (w_active_nxt[15:12] == 4'h0); end
      2'd1: begin w_nib = w_active_nxt[11:8];  w_lz = (w_active_nxt[15:8]  == 8'h00); end
      2'd2: begin w_nib = w_active_nxt[7:4];   w_lz = (w_active_nxt[15:4]  == 12'h000); end
      default: begin w_nib = w_active_nxt[3:0]; w_lz = 1'b0; end
    endcase
  end

  always_comb begin
    w_dec = 7'b1111111;
    case (w_nib)
      4'h0: w_dec = 7'b1000000;
      4'h1: w_dec = 7'b1111001;
      4'h2: w_dec = 7'b0100100;
      4'h3: w_dec = 7'b0110000;
      4'h4: w_dec = 7'b0011001;
      4'h5: w_dec = 7'b0010010;
      4'h6: w_dec = 7'b0000010;
      4'h7: w_dec = 7'b1111000;
      4'h8: w_dec = 7'b0000000;
      4'h9: w_dec = 7'b0010000;
      4'hA: w_dec = 7'b0001000;
      4'hB: w_dec = 7'b0000011;
      4'hC: w_dec = 7'b1000110;
      4'hD: w_dec = 7'b0100001;
      4'hE: w_dec = 7'b0000110;
      default: w_dec = 7'b0001110;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'b1111111;
    if (w_state_nxt == S_ON && !(LZB_EN && w_lz)) begin
      w_an_nxt  = ~(4'b1000 >> w_k_nxt);
      w_seg_nxt = w_dec;
    end
  end

  always_ff @(posedge clk_500hz or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_cnt       <= 8'd0;
      r_active    <= 16'h0000;
      r_pend_data <= 16'h0000;
      r_pend      <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_an        <= 4'b1111;
      r_seg       <= 7'b1111111;
      r_fd        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
      r_rdy_en <= 1'b1;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
      r_fd     <= w_frame_start;
      if (w_commit) begin
        r_pend <= 1'b0;
      end else if (w_xfer) begin
        r_pend      <= 1'b1;
        r_pend_data <= wr_data;
      end
    end
  end

endmodule
